// File: rtl/lacr_rx_if.sv
// Symbol and status bundle between the 8b10b decoder, lacr_rx and autonegotiation.
// The cfg_cnt/err_tot statistics exist only when LACR_RX_STATS_EN is defined.
interface lacr_rx_if;
  logic [7:0]  rx_data;
  logic        rx_is_k;
  logic        rx_valid;
  logic        rx_err;
  logic [15:0] lacr_in;
  logic        lacr_in_stb;
  logic        idle_match;
  logic        los;
  logic [2:0]  sync_sets;
`ifdef LACR_RX_STATS_EN
  logic [15:0] cfg_cnt;
  logic [15:0] err_tot;
`endif

  modport slave (
    input  rx_data, rx_is_k, rx_valid, rx_err,
    output lacr_in, lacr_in_stb, idle_match, los, sync_sets
`ifdef LACR_RX_STATS_EN
    , output cfg_cnt, err_tot
`endif
  );

  modport master (
    output rx_data, rx_is_k, rx_valid, rx_err,
    input  lacr_in, lacr_in_stb, idle_match, los, sync_sets
`ifdef LACR_RX_STATS_EN
    , input cfg_cnt, err_tot
`endif
  );
endinterface

// File: rtl/lacr_rx.sv
// Receive-side /C/ and /I/ ordered-set parser feeding PCS autonegotiation.
// Optional cfg_cnt/err_tot statistics are enabled by defining LACR_RX_STATS_EN.
module lacr_rx #(
  parameter int SYNC_SETS = 3,
  parameter int LOS_ERRS  = 4,
  parameter int IDLE_MIN  = 2
) (
  input  logic     rx_clk,
  input  logic     rst,
  lacr_rx_if.slave bus
);

  localparam int EW = $clog2(LOS_ERRS + 1);
  localparam int IW = $clog2(IDLE_MIN + 1);

  typedef enum logic [1:0] {HUNT, SECOND, CFG_LO, CFG_HI} state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [7:0]    r_lo;
  logic [15:0]   r_lacr_in;
  logic          r_stb;
  logic          r_los;
  logic [2:0]    r_sync_sets;
  logic [EW-1:0] r_err_cnt;
  logic [1:0]    r_good_run;
  logic [IW-1:0] r_idle_cnt;

  logic          w_comma;
  logic          w_cfg_sym;
  logic          w_idle_sym;
  logic          w_cap_lo;
  logic          w_cfg_done;
  logic          w_idle_done;
  logic          w_malformed;
  logic          w_good;
  logic [2:0]    w_sync_inc;
  logic [EW-1:0] w_err_inc;

  assign w_comma    = bus.rx_is_k && (bus.rx_data == 8'hBC);
  assign w_cfg_sym  = !bus.rx_is_k && ((bus.rx_data == 8'hB5) || (bus.rx_data == 8'h42));
  assign w_idle_sym = !bus.rx_is_k && ((bus.rx_data == 8'hC5) || (bus.rx_data == 8'h50));

  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) r_state <= HUNT;
    else     r_state <= w_next_state;
  end

  // An errored symbol aborts the set; a comma still opens a new one.
  always_comb begin
    w_next_state = r_state;
    if (bus.rx_valid) begin
      if (bus.rx_err) begin
        w_next_state = w_comma ? SECOND : HUNT;
      end else begin
        case (r_state)
          HUNT:    if (w_comma) w_next_state = SECOND;
          SECOND:  if (w_cfg_sym)     w_next_state = CFG_LO;
                   else if (w_comma)  w_next_state = SECOND;
                   else               w_next_state = HUNT;
          CFG_LO:  if (!bus.rx_is_k)  w_next_state = CFG_HI;
                   else if (w_comma)  w_next_state = SECOND;
                   else               w_next_state = HUNT;
          CFG_HI:  w_next_state = w_comma ? SECOND : HUNT;
          default: w_next_state = HUNT;
        endcase
      end
    end
  end

  always_comb begin
    w_cap_lo    = 1'b0;
    w_cfg_done  = 1'b0;
    w_idle_done = 1'b0;
    w_malformed = 1'b0;
    if (bus.rx_valid) begin
      if (bus.rx_err) begin
        w_malformed = 1'b1;
      end else begin
        case (r_state)
          SECOND: begin
            w_idle_done = w_idle_sym;
            w_malformed = !w_cfg_sym && !w_idle_sym && !w_comma;
          end
          CFG_LO: begin
            w_cap_lo    = !bus.rx_is_k;
            w_malformed = bus.rx_is_k;
          end
          CFG_HI: begin
            w_cfg_done  = !bus.rx_is_k;
            w_malformed = bus.rx_is_k;
          end
          default: ;
        endcase
      end
    end
  end

  assign w_good     = w_cfg_done || w_idle_done;
  assign w_sync_inc = (r_sync_sets == 3'd7) ? r_sync_sets : r_sync_sets + 3'd1;
  assign w_err_inc  = (r_err_cnt == EW'(LOS_ERRS)) ? r_err_cnt : r_err_cnt + EW'(1);

  // Config capture is suppressed entirely while out of sync.
  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      r_lo      <= 8'h00;
      r_lacr_in <= 16'h0000;
      r_stb     <= 1'b0;
    end else begin
      r_stb <= 1'b0;
      if (w_cap_lo) r_lo <= bus.rx_data;
      if (w_cfg_done && !r_los) begin
        r_lacr_in <= {bus.rx_data, r_lo};
        r_stb     <= 1'b1;
      end
    end
  end

  // In sync, every run of four good sets forgives one earlier error.
  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      r_los       <= 1'b1;
      r_sync_sets <= 3'd0;
      r_err_cnt   <= '0;
      r_good_run  <= 2'd0;
    end else if (w_malformed) begin
      r_sync_sets <= 3'd0;
      r_good_run  <= 2'd0;
      r_err_cnt   <= w_err_inc;
      if (w_err_inc == EW'(LOS_ERRS)) r_los <= 1'b1;
    end else if (w_good) begin
      r_sync_sets <= w_sync_inc;
      if (r_los) begin
        if (w_sync_inc >= 3'(SYNC_SETS)) begin
          r_los      <= 1'b0;
          r_err_cnt  <= '0;
          r_good_run <= 2'd0;
        end
      end else if (r_good_run == 2'd3) begin
        r_good_run <= 2'd0;
        if (r_err_cnt != '0) r_err_cnt <= r_err_cnt - EW'(1);
      end else begin
        r_good_run <= r_good_run + 2'd1;
      end
    end
  end

  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst)                                            r_idle_cnt <= '0;
    else if (w_malformed || w_cfg_done)                 r_idle_cnt <= '0;
    else if (w_idle_done && r_idle_cnt != IW'(IDLE_MIN)) r_idle_cnt <= r_idle_cnt + IW'(1);
  end

`ifdef LACR_RX_STATS_EN
  logic [15:0] r_cfg_cnt;
  logic [15:0] r_err_tot;

  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      r_cfg_cnt <= 16'h0000;
      r_err_tot <= 16'h0000;
    end else begin
      if (w_cfg_done && r_cfg_cnt != 16'hFFFF)  r_cfg_cnt <= r_cfg_cnt + 16'd1;
      if (w_malformed && r_err_tot != 16'hFFFF) r_err_tot <= r_err_tot + 16'd1;
    end
  end

  assign bus.cfg_cnt = r_cfg_cnt;
  assign bus.err_tot = r_err_tot;
`endif

  assign bus.lacr_in     = r_lacr_in;
  assign bus.lacr_in_stb = r_stb;
  assign bus.idle_match  = (r_idle_cnt == IW'(IDLE_MIN));
  assign bus.los         = r_los;
  assign bus.sync_sets   = r_sync_sets;

endmodule
